firc_sample_fifo: RTL

- Input sample buffer directly upstream of the complex FIR filter core.
- Accepts complex 24-bit I/Q samples from the source on a push handshake and back-pressures the source via StopIn.
- Hands samples to the filter datapath in arrival order on the filter's PullOut strobe.
- Read data is registered, so each pulled sample appears on the outputs one cycle after the pull.

---
 rtl/firc_sample_fifo.sv | 108 ++++++++++
 1 files changed

// File: rtl/firc_sample_fifo.sv
// Input sample FIFO feeding the complex FIR core: DEPTH x {I,Q} 24-bit samples, in-order delivery.
// Latency: a pushed word can be pulled from the next cycle; pulled data appears on the outputs one cycle after PullOut.
// Backpressure: StopIn rises once SKID or fewer entries are free; pushes at Full without a pull are dropped.
//
// Ports:
//   Clk, Reset            - clock, synchronous active-low reset
//   PushIn, SampI, SampQ  - source write strobe and I/Q sample
//   StopIn                - back-pressure to the source (decoded from registered Count)
//   PullOut               - read strobe from filter control
//   SampIOut, SampQOut    - registered read data; OutValid pulses when they update
//   Full, Empty, Count    - occupancy status
//   Overflow, Underflow   - sticky error flags, only live when FIRC_SAMPLE_FIFO_FLAGS_EN is defined
//
// Build option: define FIRC_SAMPLE_FIFO_FLAGS_EN to enable the sticky Overflow/Underflow flags;
// otherwise both are tied to 0.

module firc_sample_fifo #(
   parameter int  DEPTH = 8,
   parameter int  SKID  = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          PushIn,
   input  logic [23:0]   SampI,
   input  logic [23:0]   SampQ,
   output logic          StopIn,
   input  logic          PullOut,
   output logic [23:0]   SampIOut,
   output logic [23:0]   SampQOut,
   output logic          OutValid,
   output logic          Full,
   output logic          Empty,
   output logic [AW:0]   Count,
   output logic          Overflow,
   output logic          Underflow
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] STOP_LVL = (AW+1)'(DEPTH - SKID);

   // Storage word is packed {I,Q}
   logic [47:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pull_ok;
   logic          push_ok;

   // Status decodes come only from the registered Count, so no strobe reaches them combinationally
   assign Full   = (Count == FULL_LVL);
   assign Empty  = (Count == '0);
   assign StopIn = (Count >= STOP_LVL);

   // At Full a push is still taken if a pull frees a slot in the same cycle.
   // At Empty the pull is ignored even with a push: there is no fall-through.
   assign pull_ok = PullOut & ~Empty;
   assign push_ok = PushIn & (~Full | pull_ok);

   // Data array carries no reset; stale contents are never visible because the pointers are reset.
   always_ff @(posedge Clk) begin
      if (Reset && push_ok) begin
         mem[wr_ptr] <= {SampI, SampQ};
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         Count    <= '0;
         SampIOut <= '0;
         SampQOut <= '0;
         OutValid <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pull_ok) begin
            {SampIOut, SampQOut} <= mem[rd_ptr];
            rd_ptr               <= rd_ptr + AW'(1);
         end
         OutValid <= pull_ok;
         Count    <= Count + (AW+1)'(push_ok) - (AW+1)'(pull_ok);
      end
   end

`ifdef FIRC_SAMPLE_FIFO_FLAGS_EN
   // Sticky until reset. A pull that coincides with a push at Empty is not an underflow:
   // the pushed word is simply delivered on a later pull.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         Overflow  <= 1'b0;
         Underflow <= 1'b0;
      end else begin
         if (PushIn & Full & ~pull_ok) begin
            Overflow <= 1'b1;
         end
         if (PullOut & Empty & ~PushIn) begin
            Underflow <= 1'b1;
         end
      end
   end
`else
   assign Overflow  = 1'b0;
   assign Underflow = 1'b0;
`endif

endmodule
